// File: rtl/imem_read_arbiter.sv
// Two-master read arbiter in front of the instruction memory: round-robin grant,
// one outstanding transaction, and a watchdog that answers the master with SLVERR.
module imem_read_arbiter #(
    parameter int AXI_AWIDTH = 4,
    parameter int AXI_DWIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  AXI_ACLK,
    input  logic                  AXI_ARESET,
    input  logic [AXI_AWIDTH-1:0] M0_ARADDR,
    input  logic                  M0_ARVALID,
    output logic                  M0_ARREADY,
    output logic [AXI_DWIDTH-1:0] M0_RDATA,
    output logic [1:0]            M0_RRESP,
    output logic                  M0_RVALID,
    input  logic                  M0_RREADY,
    input  logic [AXI_AWIDTH-1:0] M1_ARADDR,
    input  logic                  M1_ARVALID,
    output logic                  M1_ARREADY,
    output logic [AXI_DWIDTH-1:0] M1_RDATA,
    output logic [1:0]            M1_RRESP,
    output logic                  M1_RVALID,
    input  logic                  M1_RREADY,
    output logic [AXI_AWIDTH-1:0] S_ARADDR,
    output logic                  S_ARVALID,
    input  logic                  S_ARREADY,
    input  logic [AXI_DWIDTH-1:0] S_RDATA,
    input  logic [1:0]            S_RRESP,
    input  logic                  S_RVALID,
    output logic                  S_RREADY
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_e;

    localparam logic [AXI_DWIDTH-1:0] ERR_DATA   = AXI_DWIDTH'(32'hDEADBEEF);
    localparam logic [7:0]            WDOG_LIMIT = 8'(TIMEOUT);

    state_e                state_q;
    logic                  gnt_q;
    logic                  last_q;
    logic [AXI_AWIDTH-1:0] addr_q;
    logic [7:0]            wdog_q;
    logic [1:0]            arready_q;

    logic                  busy;
    logic                  gnt_rready;
    logic                  s_hs;
    logic                  gnt_d;
    logic [7:0]            wdog_d;
    logic                  gnt_rvalid;
    logic [1:0]            gnt_rresp;
    logic [AXI_DWIDTH-1:0] gnt_rdata;

    assign busy       = (state_q == ADDR) || (state_q == DATA);
    assign gnt_rready = gnt_q ? M1_RREADY : M0_RREADY;
    assign s_hs       = S_RVALID & gnt_rready;
    assign wdog_d     = wdog_q + 8'd1;
    // On a tie the master that was not served last wins; otherwise the sole requester.
    assign gnt_d      = (M0_ARVALID & M1_ARVALID) ? ~last_q : M1_ARVALID;

    always_comb begin
        gnt_rvalid = 1'b0;
        gnt_rresp  = 2'b00;
        gnt_rdata  = '0;
        if (busy) begin
            gnt_rvalid = S_RVALID;
            gnt_rresp  = S_RRESP;
            gnt_rdata  = S_RDATA;
        end else if (state_q == ERR) begin
            gnt_rvalid = 1'b1;
            gnt_rresp  = 2'b10;
            gnt_rdata  = ERR_DATA;
        end
    end

    assign S_ARVALID  = (state_q == ADDR);
    assign S_ARADDR   = addr_q;
    assign S_RREADY   = busy & gnt_rready;

    assign M0_ARREADY = arready_q[0];
    assign M1_ARREADY = arready_q[1];
    assign M0_RVALID  = ~gnt_q & gnt_rvalid;
    assign M1_RVALID  =  gnt_q & gnt_rvalid;
    assign M0_RRESP   = gnt_q ? 2'b00 : gnt_rresp;
    assign M1_RRESP   = gnt_q ? gnt_rresp : 2'b00;
    assign M0_RDATA   = gnt_q ? '0 : gnt_rdata;
    assign M1_RDATA   = gnt_q ? gnt_rdata : '0;

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            addr_q    <= '0;
            wdog_q    <= '0;
            arready_q <= 2'b00;
        end else begin
            arready_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (M0_ARVALID | M1_ARVALID) begin
                        gnt_q     <= gnt_d;
                        addr_q    <= gnt_d ? M1_ARADDR : M0_ARADDR;
                        arready_q <= gnt_d ? 2'b10 : 2'b01;
                        wdog_q    <= '0;
                        state_q   <= ADDR;
                    end
                end
                ADDR, DATA: begin
                    // A response counts in ADDR only alongside the address handshake.
                    if (s_hs && (state_q == DATA || S_ARREADY)) begin
                        state_q <= IDLE;
                        last_q  <= gnt_q;
                    end else begin
                        wdog_q <= wdog_d;
                        if (wdog_d == WDOG_LIMIT)
                            state_q <= ERR;
                        else if (state_q == ADDR && S_ARREADY)
                            state_q <= DATA;
                    end
                end
                ERR: begin
                    if (gnt_rready) begin
                        state_q <= IDLE;
                        last_q  <= gnt_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_read_arbiter.sv
// Bench for imem_read_arbiter: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a transaction-level model.
module tb_imem_read_arbiter;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  arv, rrdy;
    logic [3:0]  ara0, ara1;
    logic        s_arready, s_rvalid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;

    logic        m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp;
    logic [3:0]  s_araddr;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Transaction-level model state
    bit         open_t, addr_done, tout;
    int         owner, last, age;
    logic [3:0] maddr;
    bit [1:0]   pulse;

    // Snapshot of DUT outputs from the most recent cycle
    logic [1:0]  sn_arready, sn_rvalid;
    logic [1:0]  sn_rresp [2];
    logic [31:0] sn_rdata [2];
    logic        sn_sarv, sn_srr;
    logic [3:0]  sn_saddr;

    always #5 clk = ~clk;

    imem_read_arbiter #(.AXI_AWIDTH(4), .AXI_DWIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .AXI_ACLK(clk), .AXI_ARESET(rst),
        .M0_ARADDR(ara0), .M0_ARVALID(arv[0]), .M0_ARREADY(m0_arready),
        .M0_RDATA(m0_rdata), .M0_RRESP(m0_rresp), .M0_RVALID(m0_rvalid), .M0_RREADY(rrdy[0]),
        .M1_ARADDR(ara1), .M1_ARVALID(arv[1]), .M1_ARREADY(m1_arready),
        .M1_RDATA(m1_rdata), .M1_RRESP(m1_rresp), .M1_RVALID(m1_rvalid), .M1_RREADY(rrdy[1]),
        .S_ARADDR(s_araddr), .S_ARVALID(s_arvalid), .S_ARREADY(s_arready),
        .S_RDATA(s_rdata), .S_RRESP(s_rresp), .S_RVALID(s_rvalid), .S_RREADY(s_rready)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        arv = 2'b00; rrdy = 2'b00; ara0 = 4'h0; ara1 = 4'h0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = 32'h0; s_rresp = 2'b00;
    endtask

    // One clock cycle: compare against the model mid-cycle, advance the model, clock.
    task automatic step();
        logic [1:0]  e_arready, e_rvalid;
        logic [1:0]  e_rresp [2];
        logic [31:0] e_rdata [2];
        logic        e_sarv, e_srr;
        logic [3:0]  e_saddr;
        #4;
        e_arready = pulse; e_rvalid = 2'b00;
        e_rresp[0] = 2'b00; e_rresp[1] = 2'b00; e_rdata[0] = 32'h0; e_rdata[1] = 32'h0;
        e_sarv = 1'b0; e_srr = 1'b0; e_saddr = 4'h0;
        if (open_t && tout) begin
            e_rvalid[owner] = 1'b1; e_rresp[owner] = 2'b10; e_rdata[owner] = 32'hDEADBEEF;
        end else if (open_t) begin
            e_sarv = !addr_done;
            e_saddr = addr_done ? 4'h0 : maddr;
            e_srr = rrdy[owner];
            e_rvalid[owner] = s_rvalid; e_rresp[owner] = s_rresp; e_rdata[owner] = s_rdata;
        end

        sn_arready = {m1_arready, m0_arready}; sn_rvalid = {m1_rvalid, m0_rvalid};
        sn_rresp[0] = m0_rresp; sn_rresp[1] = m1_rresp;
        sn_rdata[0] = m0_rdata; sn_rdata[1] = m1_rdata;
        sn_sarv = s_arvalid; sn_srr = s_rready; sn_saddr = s_araddr;

        if (chk_en) begin
            check("model_m0", 64'({m0_arready, m0_rvalid, m0_rresp, m0_rdata}),
                  64'({e_arready[0], e_rvalid[0], e_rresp[0], e_rdata[0]}));
            check("model_m1", 64'({m1_arready, m1_rvalid, m1_rresp, m1_rdata}),
                  64'({e_arready[1], e_rvalid[1], e_rresp[1], e_rdata[1]}));
            check("model_slave", 64'({s_arvalid, s_rready, (s_arvalid ? s_araddr : 4'h0)}),
                  64'({e_sarv, e_srr, e_saddr}));
        end

        if (rst) begin
            open_t = 0; tout = 0; addr_done = 0; age = 0; last = 1; pulse = 2'b00; maddr = 4'h0;
        end else begin
            pulse = 2'b00;
            if (!open_t) begin
                if (arv != 2'b00) begin
                    owner = (arv == 2'b11) ? 1 - last : (arv[0] ? 0 : 1);
                    open_t = 1; addr_done = 0; tout = 0; age = 0;
                    maddr = owner ? ara1 : ara0;
                    pulse[owner] = 1'b1;
                end
            end else if (tout) begin
                if (rrdy[owner]) begin open_t = 0; last = owner; end
            end else if (s_rvalid && rrdy[owner] && (addr_done || s_arready)) begin
                open_t = 0; last = owner;
            end else begin
                if (s_arready) addr_done = 1;
                age++;
                if (age == TIMEOUT) tout = 1;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int who, n, pulses;
        int p;
        clear_inputs();
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        check("reset_outputs", 64'({sn_arready, sn_rvalid, sn_rresp[0], sn_rresp[1], sn_sarv, sn_srr, sn_saddr}), 64'h0);
        check("reset_rdata", 64'({sn_rdata[1], sn_rdata[0]}), 64'h0);

        // Simultaneous requests alternate starting with M0
        for (int i = 0; i < 4; i++) begin
            arv = 2'b11; ara0 = 4'h1; ara1 = 4'h2; rrdy = 2'b11;
            step();
            arv = 2'b00; s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h100 + i;
            step();
            who = sn_arready[1] ? 1 : (sn_arready[0] ? 0 : -1);
            check("tie_grant", 64'(who), 64'(i % 2));
            clear_inputs();
            step();
        end

        // M0 alone, addr 3, slave answers one cycle after address presented
        arv = 2'b01; ara0 = 4'h3; rrdy = 2'b01;
        step();
        arv = 2'b00;
        step();
        pulses = sn_arready[0];
        check("m0_addr_out", 64'({sn_sarv, sn_saddr}), 64'({1'b1, 4'h3}));
        s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h00100093;
        step();
        pulses += sn_arready[0];
        check("m0_rdata", 64'({sn_rvalid[0], sn_rresp[0], sn_rdata[0]}), 64'({1'b1, 2'b00, 32'h00100093}));
        check("m1_quiet", 64'({sn_arready[1], sn_rvalid[1], sn_rresp[1], sn_rdata[1]}), 64'h0);
        clear_inputs();
        step();
        pulses += sn_arready[0];
        check("m0_arready_pulses", 64'(pulses), 64'd1);
        check("m0_done_idle", 64'({sn_rvalid, sn_sarv}), 64'h0);

        // Silent slave: watchdog error response
        arv = 2'b01; ara0 = 4'h5;
        step();
        arv = 2'b00;
        n = 0;
        do begin step(); n++; end while (!sn_rvalid[0] && n <= 40);
        check("timeout_latency", 64'(n), 64'(TIMEOUT + 1));
        s_rvalid = 1'b1; s_rdata = 32'h12345678;
        step();
        check("timeout_resp", 64'({sn_rvalid[0], sn_rresp[0], sn_rdata[0], sn_srr}),
              64'({1'b1, 2'b10, 32'hDEADBEEF, 1'b0}));
        rrdy = 2'b01;
        step();
        rrdy = 2'b00;
        step();
        check("late_rvalid_dropped", 64'({sn_rvalid, sn_srr}), 64'h0);
        clear_inputs();
        step();

        // M1 back-pressures the read data for three cycles
        arv = 2'b10; ara1 = 4'h9;
        step();
        arv = 2'b00; s_arready = 1'b1;
        step();
        check("m1_grant", 64'({sn_arready, sn_sarv, sn_saddr}), 64'({2'b10, 1'b1, 4'h9}));
        s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hCAFE0001;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold", 64'({sn_srr, sn_rvalid[1], sn_rdata[1]}), 64'({1'b0, 1'b1, 32'hCAFE0001}));
        end
        rrdy = 2'b10;
        step();
        check("bp_release", 64'({sn_srr, sn_rvalid[1]}), 64'b11);
        rrdy = 2'b00;
        step();
        check("bp_done_idle", 64'({sn_srr, sn_rvalid, sn_sarv}), 64'h0);
        clear_inputs();
        step();

        // Reset while waiting for data, then first tie goes to M0
        arv = 2'b10; ara1 = 4'h7;
        step();
        arv = 2'b00; s_arready = 1'b1;
        step();
        s_arready = 1'b0; s_rvalid = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; rrdy = 2'b11;
        step();
        check("rst_mid_outputs", 64'({sn_arready, sn_rvalid, sn_sarv, sn_srr, sn_saddr}), 64'h0);
        clear_inputs();
        arv = 2'b11;
        step();
        arv = 2'b00;
        step();
        check("rst_first_tie", 64'(sn_arready), 64'b01);
        clear_inputs();

        // Randomized traffic
        p = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: p = 0;
                    1: p = 30;
                    default: p = 80;
                endcase
            end
            rst       = ($urandom_range(0, 299) == 0);
            arv       = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            ara0      = 4'($urandom);
            ara1      = 4'($urandom);
            rrdy      = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
            s_arready = ($urandom_range(0, 99) < p);
            s_rvalid  = ($urandom_range(0, 99) < p);
            s_rdata   = $urandom;
            s_rresp   = 2'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_read_arbiter.md
IMEM_READ_ARBITER -- requirements
Module: imem_read_arbiter

Interface
REQ-001 SHALL have parameter AXI_AWIDTH, default 4: read address width of both masters and the slave.
REQ-002 SHALL have parameter AXI_DWIDTH, default 32: read data width.
REQ-003 SHALL have parameter TIMEOUT, default 16: slave response watchdog limit in cycles, legal range 2..255.
REQ-004 SHALL have port AXI_ACLK  input  1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port AXI_ARESET  input  1: reset, synchronous, active-high.
REQ-006 SHALL have ports M0_ARADDR / M1_ARADDR  input  AXI_AWIDTH: master n read address (M0 = fetch, M1 = debug/load).
REQ-007 SHALL have ports M0_ARVALID / M1_ARVALID  input  1: master n address valid.
REQ-008 SHALL have ports M0_ARREADY / M1_ARREADY  output  1: master n address accepted.
REQ-009 SHALL have ports M0_RDATA / M1_RDATA  output  AXI_DWIDTH: master n read data.
REQ-010 SHALL have ports M0_RRESP / M1_RRESP  output  2: master n read response.
REQ-011 SHALL have ports M0_RVALID / M1_RVALID  output  1: master n read data valid.
REQ-012 SHALL have ports M0_RREADY / M1_RREADY  input  1: master n read data ready.
REQ-013 SHALL have port S_ARADDR  output  AXI_AWIDTH: address to the instruction memory.
REQ-014 SHALL have port S_ARVALID  output  1: slave address valid.
REQ-015 SHALL have port S_ARREADY  input  1: slave address accepted.
REQ-016 SHALL have ports S_RDATA  input  AXI_DWIDTH and S_RRESP  input  2: slave read data and response.
REQ-017 SHALL have port S_RVALID  input  1: slave read data valid.
REQ-018 SHALL have port S_RREADY  output  1: slave read data ready.

Function
REQ-019 SHALL implement FSM states IDLE, ADDR, DATA, ERR, with at most one transaction outstanding.
REQ-020 In IDLE, any Mn_ARVALID SHALL grant one master: sole requester wins; with both requesting, the master not granted last wins; the last-granted pointer resets to M1, so M0 wins the first tie.
REQ-021 On grant, the block SHALL latch the granted ARADDR, pulse the granted Mn_ARREADY for exactly that one cycle (registered), and move to ADDR next cycle.
REQ-022 In ADDR, S_ARVALID=1 and S_ARADDR=latched address; S_ARADDR SHALL stay stable until S_ARREADY is sampled high, then the FSM SHALL go to DATA.
REQ-023 In ADDR and DATA, S_RREADY SHALL equal the granted master's RREADY, combinationally.
REQ-024 In ADDR and DATA, the granted master's RVALID, RDATA and RRESP SHALL equal S_RVALID, S_RDATA and S_RRESP combinationally.
REQ-025 When S_RVALID&S_RREADY occurs in ADDR (same cycle as S_ARREADY) or in DATA, the FSM SHALL return to IDLE and the pointer SHALL update to the granted master.
REQ-026 A new grant SHALL NOT occur in the cycle of completion; the earliest re-grant is the following IDLE cycle.
REQ-027 The non-granted master SHALL see ARREADY=0, RVALID=0, RDATA=0 and RRESP=0 at all times.
REQ-028 An 8-bit watchdog counter SHALL clear on grant and increment each cycle in ADDR/DATA; reaching TIMEOUT without completion SHALL move the FSM to ERR and drop S_ARVALID and S_RREADY.
REQ-029 In ERR, the granted master SHALL see RVALID=1, RRESP=2'b10 and RDATA=32'hDEADBEEF, held until its RREADY; the FSM SHALL then go to IDLE and update the pointer.
REQ-030 Slave responses arriving while in ERR or IDLE SHALL be ignored (S_RREADY=0).
REQ-031 Master ARVALID deasserting after grant SHALL NOT abort the transaction.

Reset
REQ-032 With AXI_ARESET high at a clock edge, the FSM SHALL enter IDLE, clear the watchdog and latched address, and set the pointer to M1; all outputs SHALL be 0 in the next cycle.
REQ-033 Reset mid-transaction (ADDR/DATA/ERR) SHALL abandon the transaction with no RVALID to any master.

Verification
REQ-034 M0 only requests addr 4'h3, slave ARREADY+RVALID after 1 cycle, RDATA=32'h00100093 -> M0_ARREADY pulse once, M0_RVALID with that data, M1 outputs all 0.
REQ-035 M0 and M1 request in the same cycle, repeated 4 times -> grants alternate M0,M1,M0,M1.
REQ-036 Slave never responds -> after TIMEOUT=16 cycles, granted master gets RVALID with RRESP=2'b10 and RDATA=32'hDEADBEEF; a late S_RVALID is not forwarded.
REQ-037 Master holds RREADY=0 for 3 cycles while S_RVALID=1 -> S_RREADY=0, FSM stays in DATA, completes on the first RREADY=1.
REQ-038 Reset asserted in DATA -> next cycle IDLE and all outputs 0; the first tie afterwards goes to M0.
